// File: rtl/seq_divider_if.sv
// seq_divider_if
// ---------------
// Groups the control-unit handshake and the operand/result buses of the
// iterative divider into one bundle. Clock and reset stay plain ports on
// the divider itself.
//
// Signals:
//   div_start        start request from the control unit
//   A, B             dividend / divisor (two's complement)
//   HI, LO           remainder / quotient result registers
//   div_end          one-cycle pulse when HI/LO hold a new result
//   div_0_exception  one-cycle pulse when a start was attempted with B == 0
//   busy             high while a division is in progress
//
// Modports:
//   master  the control unit / datapath side that issues divisions
//   slave   the divider itself
interface seq_divider_if #(
  parameter int WIDTH = 32
);

  logic             div_start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;
  logic             div_end;
  logic             div_0_exception;
  logic             busy;

  modport master (
    output div_start,
    output A,
    output B,
    input  HI,
    input  LO,
    input  div_end,
    input  div_0_exception,
    input  busy
  );

  modport slave (
    input  div_start,
    input  A,
    input  B,
    output HI,
    output LO,
    output div_end,
    output div_0_exception,
    output busy
  );

endinterface

// File: rtl/seq_divider.sv
// seq_divider
// -----------
// Iterative signed divider feeding the HI/LO register pair of the
// multicycle CPU datapath. Implements MIPS DIV semantics: the quotient
// (LO) truncates toward zero and the remainder (HI) takes the sign of the
// dividend. The division itself runs on unsigned magnitudes with one
// restoring step per clock; signs are applied in a final FIX cycle.
//
// Ports:
//   clock  system clock, rising edge
//   reset  asynchronous, active-low reset
//   bus    seq_divider_if slave modport (div_start, A, B, HI, LO,
//          div_end, div_0_exception, busy)
//
// Timing: a start accepted at edge E0 runs WIDTH steps on E1..E32, writes
// HI/LO on E33, and div_end is high during the cycle after E33.
module seq_divider #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic          clock,
  input logic          reset,
  seq_divider_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  // Working registers of the restoring divider. quo starts as the dividend
  // magnitude and has quotient bits shifted in from the right as the
  // dividend bits are shifted out into rem.
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] div_mag;
  logic [CNT_W-1:0] count;
  logic             sign_q;
  logic             sign_r;

  // Architectural result registers and registered pulses.
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             div_end_q;
  logic             div0_q;

  // Combinational helpers.
  logic             start_ok;
  logic             start_zero;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   trial;
  logic             last_step;

  // Start decode, operand magnitudes and the trial subtraction.
  // The magnitude of the most negative value wraps to itself, which read
  // as unsigned is exactly 2^(WIDTH-1), so no special case is needed.
  // The subtraction is one bit wider than the operands so its MSB is a
  // clean borrow/sign indicator.
  always_comb begin
    start_ok   = 1'b0;
    start_zero = 1'b0;
    if (state == IDLE && bus.div_start) begin
      if (bus.B != '0) begin
        start_ok = 1'b1;
      end else begin
        start_zero = 1'b1;
      end
    end

    a_mag = bus.A[WIDTH-1] ? (-bus.A) : bus.A;
    b_mag = bus.B[WIDTH-1] ? (-bus.B) : bus.B;

    rem_shift = {rem, quo[WIDTH-1]};
    trial     = rem_shift - {1'b0, div_mag};
    last_step = (count == CNT_W'(1));
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. Starts are only considered in IDLE, so a div_start
  // during RUN/FIX is ignored and one held through the div_end cycle is
  // picked up on the first IDLE edge.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (start_ok) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (last_step) begin
          state_next = FIX;
        end
      end
      FIX: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath. Operands are captured at the start edge so later changes on
  // A/B cannot disturb a running division. HI/LO are only written in FIX,
  // which is what keeps them stable across a divide-by-zero attempt.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rem       <= '0;
      quo       <= '0;
      div_mag   <= '0;
      count     <= '0;
      sign_q    <= 1'b0;
      sign_r    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      div_end_q <= 1'b0;
      div0_q    <= 1'b0;
    end else begin
      div_end_q <= 1'b0;
      div0_q    <= start_zero;
      unique case (state)
        IDLE: begin
          if (start_ok) begin
            quo     <= a_mag;
            div_mag <= b_mag;
            rem     <= '0;
            count   <= CNT_W'(WIDTH);
            sign_q  <= bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
            sign_r  <= bus.A[WIDTH-1];
          end
        end
        RUN: begin
          // Keep the difference only when it did not borrow.
          if (!trial[WIDTH]) begin
            rem <= trial[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b1};
          end else begin
            rem <= rem_shift[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b0};
          end
          count <= count - CNT_W'(1);
        end
        FIX: begin
          lo_q      <= sign_q ? (-quo) : quo;
          hi_q      <= sign_r ? (-rem) : rem;
          div_end_q <= 1'b1;
        end
        default: begin
          count <= '0;
        end
      endcase
    end
  end

  assign bus.HI              = hi_q;
  assign bus.LO              = lo_q;
  assign bus.div_end         = div_end_q;
  assign bus.div_0_exception = div0_q;
  assign bus.busy            = (state != IDLE);

endmodule
